// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one simple-dual-port SRAM (one write port, one read port) between
//   NUM_REQ requesters. A round-robin arbiter grants at most one request per
//   cycle. The granted access becomes a registered SRAM command on the next
//   cycle. Read data is returned to the issuing requester with a one-hot
//   strobe, RD_LATENCY cycles after the read enable.
//
//   Optional feature macro: ARB_PERF_CNT_EN adds two saturating 32-bit
//   performance counters (accepts, multi-request cycles).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/we_i      per-requester request valid and write select
//   req_addr_i/wdata_i    packed per-requester address / write data
//   req_ready_o           one-hot grant (accept = valid & ready)
//   rsp_valid_o           one-hot read-response strobe
//   rsp_rdata_o           read data, meaningful while rsp_valid_o != 0
//   mem_wr_*_o            SRAM write port command
//   mem_rd_*_o            SRAM read port command
//   mem_rd_data_i         SRAM read data
//   perf_grant_cnt_o      (ARB_PERF_CNT_EN) accepts since reset
//   perf_conflict_cnt_o   (ARB_PERF_CNT_EN) cycles with >= 2 requests
module sram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      mem_wr_en_o,
   output logic [ADDR_W-1:0]         mem_wr_addr_o,
   output logic [DATA_W-1:0]         mem_wr_data_o,
   output logic                      mem_rd_en_o,
   output logic [ADDR_W-1:0]         mem_rd_addr_o,
   input  logic [DATA_W-1:0]         mem_rd_data_i
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]               perf_grant_cnt_o,
   output logic [31:0]               perf_conflict_cnt_o
`endif
);

   localparam int             PTR_W     = $clog2(NUM_REQ);
   localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_found;
   logic [PTR_W:0]    scan_idx;
   logic [PTR_W:0]    ptr_next;
   logic              grant_we;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_wdata;

   logic              wr_en_p1;
   logic [ADDR_W-1:0] wr_addr_p1;
   logic [DATA_W-1:0] wr_data_p1;
   logic              rd_en_p1;
   logic [ADDR_W-1:0] rd_addr_p1;

   // One-hot id of the read in each stage; a non-zero entry doubles as the
   // stage valid. Entry 0 lines up with mem_rd_en_o, entry RD_LATENCY with
   // the cycle the SRAM presents the data.
   logic [NUM_REQ-1:0] rsp_id_p [RD_LATENCY+1];

   // ---- stage p0: round-robin arbitration (combinational) ----
   // Scan starts at the pointer and wraps; the first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
         if (!grant_found && req_valid_i[scan_idx[PTR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[PTR_W-1:0];
         end
      end
      if (rst_i) grant_found = 1'b0;

      ptr_next = {1'b0, grant_idx} + (PTR_W+1)'(1);
      if (ptr_next == NUM_REQ_W) ptr_next = '0;
   end

   assign req_ready_o = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
   assign grant_we    = req_we_i[grant_idx];
   assign grant_addr  = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign grant_wdata = req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];

   // ---- stage p1: registered SRAM command ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         wr_en_p1   <= 1'b0;
         rd_en_p1   <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
         rd_addr_p1 <= '0;
      end else begin
         wr_en_p1 <= grant_found & grant_we;
         rd_en_p1 <= grant_found & ~grant_we;
         if (grant_found) begin
            ptr_q <= ptr_next[PTR_W-1:0];
            if (grant_we) begin
               wr_addr_p1 <= grant_addr;
               wr_data_p1 <= grant_wdata;
            end else begin
               rd_addr_p1 <= grant_addr;
            end
         end
      end
   end

   // ---- stages p1..p(1+RD_LATENCY): read-response id pipeline ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s <= RD_LATENCY; s++) rsp_id_p[s] <= '0;
      end else begin
         rsp_id_p[0] <= (grant_found && !grant_we) ? req_ready_o : '0;
         for (int s = 1; s <= RD_LATENCY; s++) rsp_id_p[s] <= rsp_id_p[s-1];
      end
   end

   // Outputs are forced low while reset is held so nothing leaks out during
   // the reset cycle itself (registered state clears on the reset edge).
   assign mem_wr_en_o   = wr_en_p1 & ~rst_i;
   assign mem_rd_en_o   = rd_en_p1 & ~rst_i;
   assign mem_wr_addr_o = rst_i ? '0 : wr_addr_p1;
   assign mem_wr_data_o = rst_i ? '0 : wr_data_p1;
   assign mem_rd_addr_o = rst_i ? '0 : rd_addr_p1;
   assign rsp_valid_o   = rst_i ? '0 : rsp_id_p[RD_LATENCY];
   // SRAM data arrives in the same cycle as the last id stage, so it is
   // passed straight through rather than registered.
   assign rsp_rdata_o   = (rsp_valid_o != '0) ? mem_rd_data_i : '0;

`ifdef ARB_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic        multi_valid;
   logic [31:0] grant_cnt_q;
   logic [31:0] conflict_cnt_q;

   // Clearing the lowest set bit leaves something only if >= 2 bits were set.
   assign multi_valid = (req_valid_i & (req_valid_i - NUM_REQ'(1))) != '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (grant_found) grant_cnt_q    <= sat_inc(grant_cnt_q);
         if (multi_valid) conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
   end

   assign perf_grant_cnt_o    = grant_cnt_q;
   assign perf_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed scenarios plus randomized
// traffic, checked by a spec-level reference model and a response scoreboard.
module tb_sram_port_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int ADDR_W     = 3;
   localparam int DATA_W     = 16;
   localparam int RD_LATENCY = 1;

   logic                      clk_i = 1'b0;
   logic                      rst_i = 1'b1;
   logic [NUM_REQ-1:0]        req_valid_i = '0;
   logic [NUM_REQ-1:0]        req_we_i = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_i = '0;
   logic [NUM_REQ*DATA_W-1:0] req_wdata_i = '0;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ-1:0]        rsp_valid_o;
   logic [DATA_W-1:0]         rsp_rdata_o;
   logic                      mem_wr_en_o;
   logic [ADDR_W-1:0]         mem_wr_addr_o;
   logic [DATA_W-1:0]         mem_wr_data_o;
   logic                      mem_rd_en_o;
   logic [ADDR_W-1:0]         mem_rd_addr_o;
   logic [DATA_W-1:0]         mem_rd_data_i;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]               perf_grant_cnt_o;
   logic [31:0]               perf_conflict_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   sram_port_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i)
`ifdef ARB_PERF_CNT_EN
      , .perf_grant_cnt_o(perf_grant_cnt_o), .perf_conflict_cnt_o(perf_conflict_cnt_o)
`endif
   );

   // Simulation SRAM: synchronous write, read data RD_LATENCY cycles after rd_en.
   logic [DATA_W-1:0] sram [1<<ADDR_W];
   logic [DATA_W-1:0] rd_pipe [RD_LATENCY];
   always @(posedge clk_i) begin
      if (mem_wr_en_o) sram[mem_wr_addr_o] <= mem_wr_data_o;
      if (mem_rd_en_o) rd_pipe[0] <= sram[mem_rd_addr_o];
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rd_data_i = rd_pipe[RD_LATENCY-1];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int                id;
      logic [DATA_W-1:0] data;
      int                due;
   } rsp_t;
   rsp_t exp_q[$];
   int   rsp_log[$];
   int   glog[$];
   logic [DATA_W-1:0] last_rsp_data;
   int   last_rsp_id;

   // Pending requests as seen by the requesters.
   logic [NUM_REQ-1:0] pv = '0;
   logic               pwe [NUM_REQ];
   logic [ADDR_W-1:0]  pad [NUM_REQ];
   logic [DATA_W-1:0]  pwd [NUM_REQ];
   logic               rst_drv = 1'b1;

   // Reference model state.
   int                 mptr = 0;
   logic [DATA_W-1:0]  shadow [1<<ADDR_W];
   logic               ew = 0, er = 0;
   logic [ADDR_W-1:0]  ewa = '0, era = '0;
   logic [DATA_W-1:0]  ewd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic set_req(input int k, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      pv[k] = 1'b1; pwe[k] = we; pad[k] = a; pwd[k] = d;
   endtask

   task automatic check_cycle();
      logic [NUM_REQ-1:0] eg;
      int gk;
      if (rst_i) begin
         ew = 0; er = 0; ewa = '0; era = '0; ewd = '0;
      end
      chk("mem_wr_en", 32'(mem_wr_en_o), 32'(ew));
      chk("mem_rd_en", 32'(mem_rd_en_o), 32'(er));
      chk("mem_wr_addr", 32'(mem_wr_addr_o), 32'(ewa));
      chk("mem_wr_data", 32'(mem_wr_data_o), 32'(ewd));
      chk("mem_rd_addr", 32'(mem_rd_addr_o), 32'(era));
      eg = '0; gk = -1;
      if (!rst_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gk < 0 && pv[(mptr + i) % NUM_REQ]) gk = (mptr + i) % NUM_REQ;
         end
         if (gk >= 0) eg[gk] = 1'b1;
      end
      chk("req_ready", 32'(req_ready_o), 32'(eg));
      glog.push_back(onehot_idx(req_ready_o));
      ew = 0; er = 0;
      if (rst_i) begin
         mptr = 0;
         exp_q.delete();
      end else if (gk >= 0) begin
         mptr = (gk + 1) % NUM_REQ;
         if (pwe[gk]) begin
            shadow[pad[gk]] = pwd[gk];
            ew = 1; ewa = pad[gk]; ewd = pwd[gk];
         end else begin
            er = 1; era = pad[gk];
            exp_q.push_back('{gk, shadow[pad[gk]], cyc + 1 + RD_LATENCY});
         end
         pv[gk] = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      rst_i = rst_drv;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_valid_i[k] = pv[k];
         req_we_i[k]    = pwe[k];
         req_addr_i[k*ADDR_W +: ADDR_W] = pad[k];
         req_wdata_i[k*DATA_W +: DATA_W] = pwd[k];
      end
      @(negedge clk_i);
      check_cycle();
   endtask

   task automatic do_reset(input int n);
      pv = '0;
      rst_drv = 1'b1;
      repeat (n) step();
      rst_drv = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (pv != '0 && n < 30) begin
         step();
         n++;
      end
      chk(name, 32'(pv), 32'd0);
   endtask

   // Response monitor: every strobe must match the oldest outstanding read.
   always @(negedge clk_i) begin
      rsp_t e;
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         checks++; failures++;
         $display("FAIL rsp_missing: got none expected id %0d at cycle %0d", exp_q[0].id, exp_q[0].due);
         void'(exp_q.pop_front());
      end
      if (rsp_valid_o != '0) begin
         rsp_log.push_back(cyc);
         last_rsp_data = rsp_rdata_o;
         last_rsp_id   = onehot_idx(rsp_valid_o);
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: got %0h expected 0 (cycle %0d)", rsp_valid_o, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_valid_o), 32'(1) << e.id);
            chk("rsp_data", 32'(rsp_rdata_o), 32'(e.data));
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      int exp_order2 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp_order3 [3] = '{3, 1, 2};
      for (int a = 0; a < (1<<ADDR_W); a++) begin
         sram[a] = '0; shadow[a] = '0;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         pwe[k] = 0; pad[k] = '0; pwd[k] = '0;
      end
      rd_pipe[0] = '0;

      // Reset state
      do_reset(2);
      chk("reset_ready", 32'(req_ready_o), 32'd0);
      chk("reset_rsp", 32'(rsp_valid_o), 32'd0);

      // 1: requester 2 writes A5A5 to addr 3 then reads it back
      set_req(2, 1'b1, 3'd3, 16'hA5A5);
      wait_idle("t1_wr_accept");
      set_req(2, 1'b0, 3'd3, 16'h0000);
      wait_idle("t1_rd_accept");
      repeat (RD_LATENCY + 2) step();
      chk("t1_rdata", 32'(last_rsp_data), 32'h0000A5A5);
      chk("t1_rsp_id", 32'(last_rsp_id), 32'd2);

      // 2: all four valid for 8 cycles from pointer 0
      do_reset(1);
      glog.delete();
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < NUM_REQ; k++)
            if (!pv[k]) set_req(k, 1'b1, ADDR_W'($urandom_range(7)), DATA_W'($urandom));
         step();
      end
      pv = '0;
      step();
      for (int i = 0; i < 8; i++) chk("t2_grant_order", 32'(glog[i]), 32'(exp_order2[i]));
`ifdef ARB_PERF_CNT_EN
      chk("t6_perf_grant", perf_grant_cnt_o, 32'd8);
      chk("t6_perf_conflict", perf_conflict_cnt_o, 32'd8);
`endif

      // 3: pointer at 2, requesters 1 and 3 -> 3 first, then 1, pointer back at 2
      do_reset(1);
      set_req(1, 1'b1, 3'd1, 16'h1111);
      wait_idle("t3_setup");
      glog.delete();
      set_req(1, 1'b1, 3'd5, 16'h5151);
      set_req(3, 1'b1, 3'd6, 16'h3636);
      step();
      step();
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, ADDR_W'(k), '0);
      step();
      for (int i = 0; i < 3; i++) chk("t3_grant_order", 32'(glog[i]), 32'(exp_order3[i]));
      pv = '0;
      wait_idle("t3_drain");
      repeat (RD_LATENCY + 2) step();

      // 4: four back-to-back reads from different requesters
      do_reset(1);
      for (int a = 0; a < 4; a++) begin
         set_req(0, 1'b1, ADDR_W'(a), DATA_W'(16'hC000 + a * 16'h0111));
         wait_idle("t4_preload");
      end
      rsp_log.delete();
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, ADDR_W'(k), '0);
      repeat (8) step();
      chk("t4_rsp_count", 32'(rsp_log.size()), 32'd4);
      for (int i = 1; i < rsp_log.size(); i++)
         chk("t4_rsp_back_to_back", 32'(rsp_log[i] - rsp_log[0]), 32'(i));

      // 5: reset while two reads are in flight
      do_reset(1);
      set_req(0, 1'b0, 3'd2, '0);
      set_req(1, 1'b0, 3'd3, '0);
      step();
      step();
      rst_drv = 1'b1;
      step();
      chk("t5_rst_outputs", 32'({req_ready_o, rsp_valid_o, mem_wr_en_o, mem_rd_en_o}), 32'd0);
      rst_drv = 1'b0;
      rsp_log.delete();
      repeat (5) step();
      chk("t5_no_rsp_after_reset", 32'(rsp_log.size()), 32'd0);
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, ADDR_W'(k), '0);
      step();
      chk("t5_ptr_after_reset", 32'(glog[glog.size()-1]), 32'd0);
      pv = '0;
      repeat (3) step();

      // Randomized traffic, with occasional withdrawals
      do_reset(1);
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (pv[k]) begin
               if ($urandom_range(7) == 0) pv[k] = 1'b0;
            end else if ($urandom_range(1) == 1) begin
               set_req(k, 1'($urandom_range(1)), ADDR_W'($urandom_range(7)), DATA_W'($urandom));
            end
         end
         step();
      end
      pv = '0;
      repeat (RD_LATENCY + 4) step();
      chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
